// File: rtl/stream_crop.sv
// Crops a rectangular window out of a raster-order pixel stream; one output register, latency 1.
// Optional crop_output_TLAST on the final window pixel when STREAM_CROP_TLAST_EN is defined.
module stream_crop #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS         = 100,
    parameter int IN_COLS         = 160,
    parameter int OUT_ROWS        = 48,
    parameter int OUT_COLS        = 48,
    parameter int Y_1             = 10,
    parameter int X_1             = 10
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       ap_ready,
    input  logic [PIXEL_BIT_WIDTH-1:0] crop_input_TDATA,
    input  logic                       crop_input_TVALID,
    output logic                       crop_input_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] crop_output_TDATA,
    output logic                       crop_output_TVALID,
`ifdef STREAM_CROP_TLAST_EN
    output logic                       crop_output_TLAST,
`endif
    input  logic                       crop_output_TREADY
);

    localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;

    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(Y_1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(Y_1 + OUT_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(IN_ROWS - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(X_1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(X_1 + OUT_COLS - 1);
    localparam logic [COL_W-1:0] COL_END   = COL_W'(IN_COLS - 1);

    if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_bad_window
        $error("stream_crop: crop window exceeds the input frame");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [PIXEL_BIT_WIDTH-1:0] data_q, data_d;
    logic                       vld_q, vld_d;
    logic                       tlast_q, tlast_d;

    logic in_win;
    logic in_ready;
    logic beat;
    logic last_beat;

    assign in_win    = (row_q >= ROW_FIRST) && (row_q <= ROW_LAST) &&
                       (col_q >= COL_FIRST) && (col_q <= COL_LAST);
    // Out-of-window beats are always consumable: they never touch the output register.
    assign in_ready  = (state_q == RUN) && (!in_win || !vld_q || crop_output_TREADY);
    assign beat      = crop_input_TVALID && in_ready;
    assign last_beat = (row_q == ROW_END) && (col_q == COL_END);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        vld_d   = vld_q;
        tlast_d = tlast_q;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (beat) begin
                    if (last_beat) begin
                        state_d = DRAIN;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == COL_END) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!vld_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A load on the same cycle as a drain overwrites, keeping valid high.
        if (vld_q && crop_output_TREADY) vld_d = 1'b0;
        if (beat && in_win) begin
            data_d  = crop_input_TDATA;
            vld_d   = 1'b1;
            tlast_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            tlast_q <= tlast_d;
        end
    end

    assign ap_done            = (state_q == DONE);
    assign ap_ready           = (state_q == DONE);
    assign ap_idle            = (state_q == IDLE);
    assign crop_input_TREADY  = in_ready;
    assign crop_output_TDATA  = data_q;
    assign crop_output_TVALID = vld_q;
`ifdef STREAM_CROP_TLAST_EN
    assign crop_output_TLAST  = tlast_q;
`else
    logic unused_tlast;
    assign unused_tlast = tlast_q;
`endif

endmodule

// File: tb/tb_stream_crop.sv
// Self-checking bench for stream_crop: random handshakes against a window-crop reference model.
module tb_stream_crop;

    localparam int W        = 16;
    localparam int IN_ROWS  = 100;
    localparam int IN_COLS  = 160;
    localparam int OUT_ROWS = 48;
    localparam int OUT_COLS = 48;
    localparam int Y_1      = 10;
    localparam int X_1      = 10;
    localparam int BIG      = 1000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         done, idle, ready;
    logic [W-1:0] in_data;
    logic         in_valid, in_ready;
    logic [W-1:0] out_data;
    logic         out_valid, out_ready;
    logic         tlast;

    stream_crop dut (
        .ap_clk             (clk),
        .ap_rst_n           (rst_n),
        .ap_start           (start),
        .ap_done            (done),
        .ap_idle            (idle),
        .ap_ready           (ready),
        .crop_input_TDATA   (in_data),
        .crop_input_TVALID  (in_valid),
        .crop_input_TREADY  (in_ready),
        .crop_output_TDATA  (out_data),
        .crop_output_TVALID (out_valid),
`ifdef STREAM_CROP_TLAST_EN
        .crop_output_TLAST  (tlast),
`endif
        .crop_output_TREADY (out_ready)
    );

`ifndef STREAM_CROP_TLAST_EN
    assign tlast = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int k_in;
    int done_cnt = 0;
    int done_wo_ready = 0;
    int out_q[$];
    bit last_q[$];
    int exp_q[$];
    int valid_pct = 100;
    int ready_pct = 100;
    bit hold_ready_low = 0;
    bit pulse_start = 0;

    // Expected output: every frame position inside the window, raster order, pixel value = index.
    function automatic void build_model();
        exp_q.delete();
        for (int r = 0; r < IN_ROWS; r++)
            for (int c = 0; c < IN_COLS; c++)
                if (r >= Y_1 && r < Y_1 + OUT_ROWS && c >= X_1 && c < X_1 + OUT_COLS)
                    exp_q.push_back(r * IN_COLS + c);
    endfunction

    task automatic cycle();
        @(negedge clk);
        start       = pulse_start;
        pulse_start = 1'b0;
        in_valid    = (int'($urandom_range(99)) < valid_pct);
        in_data     = W'(k_in);
        out_ready   = hold_ready_low ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
        #4;
        if (in_valid && in_ready) k_in++;
        if (out_valid && out_ready) begin
            out_q.push_back(int'(out_data));
            last_q.push_back(tlast);
        end
        if (done) begin
            done_cnt++;
            if (!ready) done_wo_ready++;
        end
    endtask

    task automatic start_frame();
        k_in = 0;
        out_q.delete();
        last_q.delete();
        pulse_start = 1'b1;
    endtask

    task automatic run_until(input int max_in, input int max_out, output bit timed_out);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && k_in < max_in && out_q.size() < max_out && n < 60000) begin
            cycle();
            n++;
        end
        timed_out = (n >= 60000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || ready !== 1'b0 ||
            idle !== 1'b1 || out_data !== '0 || tlast !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b rdy=%b done=%b ready=%b idle=%b data=%0d last=%b required 0 0 0 0 1 0 0",
                     out_valid, in_ready, done, ready, idle, out_data, tlast);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        cycle(); cycle();
        total++;
        if (idle !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got idle=%b tready=%b required 1 0", idle, in_ready);
        end
    endtask

    task automatic test_full_rate();
        bit to;
        int mism = 0;
        int d0 = done_cnt;
        valid_pct = 100; ready_pct = 100;
        start_frame();
        run_until(3000, BIG, to);
        total++;
        if (idle !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL run_status got idle=%b ready=%b required 0 0", idle, ready);
        end
        pulse_start = 1'b1;
        run_until(BIG, BIG, to);
        total++;
        if (to) begin bad++; $display("FAIL full_rate_timeout got timeout required done"); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] != exp_q[i]) mism++;
        total++;
        if (out_q.size() != 2304 || mism != 0) begin
            bad++;
            $display("FAIL full_rate_seq got count=%0d mism=%0d required count=2304 mism=0", out_q.size(), mism);
        end
        total++;
        if (out_q.size() == 0 || out_q[0] != 1610 || out_q[out_q.size()-1] != 9177) begin
            bad++;
            $display("FAIL first_last got first=%0d last=%0d required 1610 9177",
                     out_q.size() ? out_q[0] : -1, out_q.size() ? out_q[out_q.size()-1] : -1);
        end
        total++;
        if (done_cnt - d0 != 1 || k_in != IN_ROWS * IN_COLS) begin
            bad++;
            $display("FAIL start_ignored got done=%0d beats=%0d required 1 %0d", done_cnt - d0, k_in, IN_ROWS * IN_COLS);
        end
`ifdef STREAM_CROP_TLAST_EN
        begin
            int ones = 0;
            foreach (last_q[i]) if (last_q[i]) ones++;
            total++;
            if (ones != 1 || last_q.size() == 0 || last_q[last_q.size()-1] != 1'b1) begin
                bad++;
                $display("FAIL tlast got ones=%0d required 1 on beat 2304", ones);
            end
        end
`endif
    endtask

    task automatic test_stall();
        bit to;
        int n, mism = 0, unstable = 0;
        logic [W-1:0] held;
        valid_pct = 100; ready_pct = 100;
        start_frame();
        run_until(BIG, 100, to);
        n = out_q.size();
        hold_ready_low = 1'b1;
        cycle();
        held = out_data;
        for (int i = 0; i < 999; i++) begin
            cycle();
            if (!out_valid || out_data !== held) unstable++;
        end
        total++;
        if (unstable != 0 || int'(held) != exp_q[n]) begin
            bad++;
            $display("FAIL stall_hold got unstable=%0d data=%0d required 0 %0d", unstable, held, exp_q[n]);
        end
        total++;
        if (k_in != exp_q[n+1] || in_ready !== 1'b0 || out_q.size() != n) begin
            bad++;
            $display("FAIL stall_input got beats=%0d tready=%b outs=%0d required %0d 0 %0d",
                     k_in, in_ready, out_q.size(), exp_q[n+1], n);
        end
        hold_ready_low = 1'b0;
        run_until(BIG, BIG, to);
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] != exp_q[i]) mism++;
        total++;
        if (to || out_q.size() != exp_q.size() || mism != 0) begin
            bad++;
            $display("FAIL stall_seq got count=%0d mism=%0d to=%b required count=%0d mism=0",
                     out_q.size(), mism, to, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        valid_pct = 100; ready_pct = 100;
        start_frame();
        run_until(5000, BIG, to);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || ready !== 1'b0 ||
            idle !== 1'b1 || out_data !== '0 || tlast !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset got v=%b rdy=%b done=%b ready=%b idle=%b data=%0d last=%b required 0 0 0 0 1 0 0",
                     out_valid, in_ready, done, ready, idle, out_data, tlast);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        int m1 = 0, m2 = 0, c1;
        int d0 = done_cnt;
        valid_pct = 75; ready_pct = 50;
        start_frame();
        run_until(BIG, BIG, to1);
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] != exp_q[i]) m1++;
        c1 = out_q.size();
        total++;
        if (to1 || c1 != exp_q.size() || m1 != 0) begin
            bad++;
            $display("FAIL frame1_seq got count=%0d mism=%0d to=%b required count=%0d mism=0", c1, m1, to1, exp_q.size());
        end
        start_frame();
        run_until(BIG, BIG, to2);
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            if (out_q[i] != exp_q[i]) m2++;
        total++;
        if (to2 || out_q.size() != exp_q.size() || m2 != 0) begin
            bad++;
            $display("FAIL frame2_seq got count=%0d mism=%0d to=%b required count=%0d mism=0",
                     out_q.size(), m2, to2, exp_q.size());
        end
        total++;
        if (done_cnt - d0 != 2 || done_wo_ready != 0) begin
            bad++;
            $display("FAIL done_pulses got done=%0d no_ready=%0d required 2 0", done_cnt - d0, done_wo_ready);
        end
        cycle();
        total++;
        if (idle !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL back_to_idle got idle=%b done=%b required 1 0", idle, done);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_full_rate();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
